// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus of the instruction fetch unit: redirect inputs, ROM port and decode-facing outputs.
// Performance counter outputs exist only when IFU_PERF_CNT_EN is defined.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_stall;
  logic                  i_branch_taken;
  logic [15:0]           i_branch_offset;
  logic                  i_jump;
  logic [25:0]           i_jump_index;
  logic                  i_jump_reg;
  logic [ADDR_WIDTH-1:0] i_jump_reg_addr;
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic [DATA_WIDTH-1:0] i_rom_data;
  logic [DATA_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic [ADDR_WIDTH-1:0] o_pc_plus4;
  logic                  o_valid;
  logic                  o_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]           o_fetch_cnt;
  logic [31:0]           o_stall_cnt;
`endif

  // master = core/ROM side driving redirects, slave = the fetch unit itself
  modport master (
    output i_stall, i_branch_taken, i_branch_offset, i_jump, i_jump_index,
           i_jump_reg, i_jump_reg_addr, i_rom_data,
    input  o_rom_addr, o_instr, o_pc, o_pc_plus4, o_valid, o_fault
`ifdef IFU_PERF_CNT_EN
    , input o_fetch_cnt, o_stall_cnt
`endif
  );

  modport slave (
    input  i_stall, i_branch_taken, i_branch_offset, i_jump, i_jump_index,
           i_jump_reg, i_jump_reg_addr, i_rom_data,
    output o_rom_addr, o_instr, o_pc, o_pc_plus4, o_valid, o_fault
`ifdef IFU_PERF_CNT_EN
    , output o_fetch_cnt, o_stall_cnt
`endif
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC register and next-PC select in front of a combinational, word-indexed instruction ROM.
// Optional fetch/stall counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ROM_BLOCKS_NUM = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  instruction_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(ROM_BLOCKS_NUM - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [ADDR_WIDTH-1:0] tgt_idx;
  logic                  jr_misaligned;
  logic                  out_of_range;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  // Priority-ordered redirect; only JR can produce a non-word-aligned target.
  always_comb begin
    tgt           = pc_plus4;
    jr_misaligned = 1'b0;
    if (bus.i_jump_reg) begin
      tgt           = bus.i_jump_reg_addr;
      jr_misaligned = |bus.i_jump_reg_addr[1:0];
    end else if (bus.i_jump) begin
      tgt = {pc_plus4[ADDR_WIDTH-1:28], bus.i_jump_index, 2'b00};
    end else if (bus.i_branch_taken) begin
      tgt = pc_plus4 + {{(ADDR_WIDTH-18){bus.i_branch_offset[15]}}, bus.i_branch_offset, 2'b00};
    end
  end

  assign tgt_idx      = {2'b00, tgt[ADDR_WIDTH-1:2]};
  assign out_of_range = tgt_idx > MAX_IDX;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.i_stall) begin
          // Offending target is latched so it is visible on o_pc while halted.
          pc_d = tgt;
          if (jr_misaligned || out_of_range) state_d = HALT;
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.o_rom_addr = {2'b00, pc_q[ADDR_WIDTH-1:2]};
  assign bus.o_valid    = (state_q == RUN);
  assign bus.o_fault    = (state_q == HALT);
  assign bus.o_instr    = bus.o_valid ? bus.i_rom_data : '0;
  assign bus.o_pc       = pc_q;
  assign bus.o_pc_plus4 = pc_plus4;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Counters only move in RUN, so they freeze in BOOT and HALT; both saturate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == RUN) begin
      if (bus.i_stall) begin
        if (~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        if (~&fetch_cnt_q) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  assign bus.o_fetch_cnt = fetch_cnt_q;
  assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected per-edge outputs go through a scoreboard queue.
module tb_instruction_fetch_unit;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();

  instruction_fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROM_BLOCKS_NUM(128), .RESET_PC(32'h0)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input logic [31:0] idx);
    if (idx == 32'd0) return 32'h2008_0005;
    return 32'hA000_0000 | idx;
  endfunction

  assign ifc.i_rom_data = rom_val(ifc.o_rom_addr);

  typedef struct {
    logic        v;
    logic        f;
    logic [31:0] pc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic v, input logic f, input logic [31:0] pc);
    chk("valid",    {31'd0, ifc.o_valid}, {31'd0, v});
    chk("fault",    {31'd0, ifc.o_fault}, {31'd0, f});
    chk("pc",       ifc.o_pc, pc);
    chk("pc_plus4", ifc.o_pc_plus4, pc + 32'd4);
    chk("rom_addr", ifc.o_rom_addr, pc >> 2);
    chk("instr",    ifc.o_instr, v ? rom_val(pc >> 2) : 32'd0);
  endtask

  // Push expectation for the state after the next edge, then pop and compare 1ns past it.
  task automatic tick(input logic v, input logic f, input logic [31:0] pc);
    exp_t e;
    e.v = v; e.f = f; e.pc = pc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    total++;
    assert (sbq.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty observed=%0d expected=1", sbq.size());
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      expect_out(e.v, e.f, e.pc);
    end
  endtask

  task automatic clear_redirects();
    ifc.i_stall        = 1'b0;
    ifc.i_branch_taken = 1'b0;
    ifc.i_jump         = 1'b0;
    ifc.i_jump_reg     = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    expect_out(1'b0, 1'b0, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    expect_out(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n               = 1'b0;
    ifc.i_stall         = 1'b0;
    ifc.i_branch_taken  = 1'b0;
    ifc.i_branch_offset = 16'h0;
    ifc.i_jump          = 1'b0;
    ifc.i_jump_index    = 26'h0;
    ifc.i_jump_reg      = 1'b0;
    ifc.i_jump_reg_addr = 32'h0;

    #2 expect_out(1'b0, 1'b0, 32'h0);
    #10 rst_n = 1'b1;
    #1 expect_out(1'b0, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_cnt_rst", ifc.o_fetch_cnt, 32'd0);
    chk("stall_cnt_rst", ifc.o_stall_cnt, 32'd0);
`endif

    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd4);
    tick(1'b1, 1'b0, 32'd8);

    // Stall three cycles at pc 8; a jump raised during the stall must be ignored.
    ifc.i_stall      = 1'b1;
    ifc.i_jump       = 1'b1;
    ifc.i_jump_index = 26'h30;
    tick(1'b1, 1'b0, 32'd8);
    ifc.i_jump = 1'b0;
    tick(1'b1, 1'b0, 32'd8);
    tick(1'b1, 1'b0, 32'd8);
`ifdef IFU_PERF_CNT_EN
    chk("stall_cnt", ifc.o_stall_cnt, 32'd3);
    chk("fetch_cnt", ifc.o_fetch_cnt, 32'd2);
`endif
    ifc.i_stall = 1'b0;
    tick(1'b1, 1'b0, 32'd12);
    tick(1'b1, 1'b0, 32'd16);

    ifc.i_branch_taken  = 1'b1;
    ifc.i_branch_offset = 16'hFFFE;
    tick(1'b1, 1'b0, 32'd12);
    ifc.i_branch_taken = 1'b0;
    tick(1'b1, 1'b0, 32'd16);

    ifc.i_jump          = 1'b1;
    ifc.i_jump_index    = 26'h10;
    ifc.i_branch_taken  = 1'b1;
    ifc.i_branch_offset = 16'h0005;
    tick(1'b1, 1'b0, 32'd64);

    ifc.i_branch_taken  = 1'b0;
    ifc.i_jump_reg      = 1'b1;
    ifc.i_jump_reg_addr = 32'd40;
    ifc.i_jump_index    = 26'h20;
    tick(1'b1, 1'b0, 32'd40);
    clear_redirects();

    // Asynchronous reset mid-run at pc 40.
    pulse_reset();
`ifdef IFU_PERF_CNT_EN
    chk("fetch_cnt_clr", ifc.o_fetch_cnt, 32'd0);
`endif
    tick(1'b1, 1'b0, 32'd0);

    ifc.i_jump_reg      = 1'b1;
    ifc.i_jump_reg_addr = 32'h0000_0006;
    tick(1'b0, 1'b1, 32'd6);
    ifc.i_jump_reg     = 1'b0;
    ifc.i_branch_taken = 1'b1;
    tick(1'b0, 1'b1, 32'd6);
    ifc.i_branch_taken = 1'b0;
    tick(1'b0, 1'b1, 32'd6);

    pulse_reset();
    tick(1'b1, 1'b0, 32'd0);
    ifc.i_branch_taken  = 1'b1;
    ifc.i_branch_offset = 16'h007F;
    tick(1'b0, 1'b1, 32'd512);
    ifc.i_branch_taken = 1'b0;
    tick(1'b0, 1'b1, 32'd512);

    // Last legal word (127) is fetched, sequential step past it halts.
    pulse_reset();
    tick(1'b1, 1'b0, 32'd0);
    ifc.i_branch_taken  = 1'b1;
    ifc.i_branch_offset = 16'h007E;
    tick(1'b1, 1'b0, 32'd508);
    ifc.i_branch_taken = 1'b0;
    tick(1'b0, 1'b1, 32'd512);
    tick(1'b0, 1'b1, 32'd512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
